// File: rtl/serial_frame_tx.sv
// Serial frame transmitter front end: latches one {port, len, data} request and
// shifts out start bit, port, len and payload MSB-first, followed by an idle gap.
module serial_frame_tx #(
  parameter int PORT_W  = 2,
  parameter int LEN_W   = 4,
  parameter int DATA_W  = 15,
  parameter int GAP_CYC = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [PORT_W-1:0] req_port,
  input  logic [LEN_W-1:0]  req_len,
  input  logic [DATA_W-1:0] req_data,
  input  logic              abort,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  localparam int HW = PORT_W + LEN_W;
  localparam int CW = (PORT_W > LEN_W + 1) ? PORT_W : LEN_W + 1;
  localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_PORT, S_LEN, S_DATA, S_GAP
  } state_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic [HW-1:0]     hdr_q, hdr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              ser_q, ser_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              accept, in_frame;

  // ready is raised one cycle early (last gap cycle) so the accept edge
  // lands exactly at gap end and back-to-back frames see only GAP_CYC idles.
  assign accept   = req_valid && ready_q;
  assign in_frame = (state_q == S_START) || (state_q == S_PORT) ||
                    (state_q == S_LEN)   || (state_q == S_DATA);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    data_d  = data_q;
    ser_d   = 1'b1;
    ready_d = 1'b0;
    busy_d  = 1'b1;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        busy_d  = 1'b0;
        ready_d = 1'b1;
      end
      S_START: begin
        ser_d   = hdr_q[HW-1];
        hdr_d   = hdr_q << 1;
        cnt_d   = CW'(PORT_W - 1);
        state_d = S_PORT;
      end
      S_PORT: begin
        ser_d = hdr_q[HW-1];
        hdr_d = hdr_q << 1;
        if (cnt_q == '0) begin
          cnt_d   = CW'(LEN_W - 1);
          state_d = S_LEN;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_LEN: begin
        if (cnt_q != '0) begin
          ser_d = hdr_q[HW-1];
          hdr_d = hdr_q << 1;
          cnt_d = cnt_q - CW'(1);
        end else if (len_q != '0) begin
          ser_d   = data_q[DATA_W-1];
          data_d  = data_q << 1;
          cnt_d   = CW'(len_q) - CW'(1);
          state_d = S_DATA;
        end else begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYC - 1);
          ready_d = (GAP_CYC == 1);
          done_d  = 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q != '0) begin
          ser_d  = data_q[DATA_W-1];
          data_d = data_q << 1;
          cnt_d  = cnt_q - CW'(1);
        end else begin
          state_d = S_GAP;
          gap_d   = GW'(GAP_CYC - 1);
          ready_d = (GAP_CYC == 1);
          done_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end else begin
          gap_d   = gap_q - GW'(1);
          ready_d = (gap_q == GW'(1));
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase

    if (abort && in_frame) begin
      state_d = S_GAP;
      gap_d   = GW'(GAP_CYC - 1);
      ready_d = (GAP_CYC == 1);
      ser_d   = 1'b1;
      done_d  = 1'b0;
    end

    // Payload is pre-aligned so data[N-1] sits at the MSB of the shifter.
    if (accept) begin
      state_d = S_START;
      ser_d   = 1'b0;
      busy_d  = 1'b1;
      ready_d = 1'b0;
      done_d  = 1'b0;
      cnt_d   = '0;
      gap_d   = '0;
      hdr_d   = {req_port, req_len};
      len_d   = req_len;
      data_d  = req_data << (DATA_W - int'(req_len));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      hdr_q   <= '0;
      len_q   <= '0;
      data_q  <= '0;
      ser_q   <= 1'b1;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      data_q  <= data_d;
      ser_q   <= ser_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign ser_out   = ser_q;
  assign req_ready = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Directed + random bench for serial_frame_tx; expected waveforms come from a
// per-frame bit list built straight from the frame format.
module tb_serial_frame_tx;
  localparam int PW = 2, LW = 4, DW = 15, GC = 2;

  logic          clk = 1'b0;
  logic          rst, req_valid, abort;
  logic          req_ready, ser_out, busy, done;
  logic [PW-1:0] req_port;
  logic [LW-1:0] req_len;
  logic [DW-1:0] req_data;

  int n_pass = 0, n_fail = 0, n_total = 0;

  typedef struct packed { logic s; logic b; logic d; logic r; } exp_t;
  exp_t exp_q[$];

  serial_frame_tx #(.PORT_W(PW), .LEN_W(LW), .DATA_W(DW), .GAP_CYC(GC)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_port(req_port), .req_len(req_len), .req_data(req_data),
    .abort(abort), .ser_out(ser_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Expected per-cycle outputs, index 0 = cycle after the accept edge.
  function automatic void build_exp(input logic [PW-1:0] p, input logic [LW-1:0] l,
                                    input logic [DW-1:0] d, input int abort_at);
    logic bits[$];
    int   f;
    bit   ab;
    exp_t e;
    exp_q.delete();
    bits.push_back(1'b0);
    for (int k = PW-1; k >= 0; k--) bits.push_back(p[k]);
    for (int k = LW-1; k >= 0; k--) bits.push_back(l[k]);
    for (int k = int'(l)-1; k >= 0; k--) bits.push_back(d[k]);
    f  = bits.size();
    ab = (abort_at >= 0) && (abort_at < f);
    if (ab) f = abort_at + 1;
    for (int i = 0; i < f; i++) begin
      e = '{s: bits[i], b: 1'b1, d: 1'b0, r: 1'b0};
      exp_q.push_back(e);
    end
    for (int g = 0; g < GC; g++) begin
      e = '{s: 1'b1, b: 1'b1, d: (!ab && g == 0), r: (g == GC-1)};
      exp_q.push_back(e);
    end
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, " idle ser"},   32'(ser_out),   32'd1);
    chk({tag, " idle busy"},  32'(busy),      32'd0);
    chk({tag, " idle done"},  32'(done),      32'd0);
    chk({tag, " idle ready"}, 32'(req_ready), 32'd1);
  endtask

  task automatic accept_req(input string tag, input logic [PW-1:0] p,
                            input logic [LW-1:0] l, input logic [DW-1:0] d);
    int w = 0;
    req_port = p; req_len = l; req_data = d; req_valid = 1'b1;
    while (!req_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({tag, " ready_wait"}, 32'(w < 50), 32'd1);
    @(negedge clk);
  endtask

  // Called at the negedge of cycle 0 of a frame that was just accepted.
  task automatic check_frame(input string tag, input logic [PW-1:0] p,
                             input logic [LW-1:0] l, input logic [DW-1:0] d,
                             input int abort_at, input int limit, input bit hold,
                             input logic [PW-1:0] np, input logic [LW-1:0] nl,
                             input logic [DW-1:0] nd);
    int n;
    build_exp(p, l, d, abort_at);
    n = (limit >= 0) ? limit : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s ser[%0d]", tag, i),   32'(ser_out),   32'(exp_q[i].s));
      chk($sformatf("%s busy[%0d]", tag, i),  32'(busy),      32'(exp_q[i].b));
      chk($sformatf("%s done[%0d]", tag, i),  32'(done),      32'(exp_q[i].d));
      chk($sformatf("%s ready[%0d]", tag, i), 32'(req_ready), 32'(exp_q[i].r));
      if (i == 0) begin
        if (hold) begin
          req_port = np; req_len = nl; req_data = nd;
        end else begin
          req_valid = 1'b0;
          req_port = PW'($urandom); req_len = LW'($urandom); req_data = DW'($urandom);
        end
      end
      abort = (i == abort_at);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  initial begin
    logic [PW-1:0] p;
    logic [LW-1:0] l;
    logic [DW-1:0] d;
    int ab;

    rst = 1'b1; req_valid = 1'b0; abort = 1'b0;
    req_port = '0; req_len = '0; req_data = '0;
    repeat (3) @(negedge clk);
    chk("reset ser",   32'(ser_out),   32'd1);
    chk("reset ready", 32'(req_ready), 32'd0);
    chk("reset busy",  32'(busy),      32'd0);
    chk("reset done",  32'(done),      32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("post_reset");

    accept_req("basic", 2'd3, 4'd3, 15'h7FF5);
    check_frame("basic", 2'd3, 4'd3, 15'h7FF5, -1, -1, 1'b0, '0, '0, '0);
    check_idle("basic");

    d = DW'($urandom);
    accept_req("zero", 2'd1, 4'd0, d);
    check_frame("zero", 2'd1, 4'd0, d, -1, -1, 1'b0, '0, '0, '0);
    check_idle("zero");

    accept_req("max", 2'd0, 4'd15, 15'h5555);
    check_frame("max", 2'd0, 4'd15, 15'h5555, -1, -1, 1'b0, '0, '0, '0);
    check_idle("max");

    accept_req("b2b_a", 2'd2, 4'd5, 15'h0013);
    check_frame("b2b_a", 2'd2, 4'd5, 15'h0013, -1, -1, 1'b1, 2'd1, 4'd4, 15'h000A);
    check_frame("b2b_b", 2'd1, 4'd4, 15'h000A, -1, -1, 1'b0, '0, '0, '0);
    check_idle("b2b");

    d = DW'($urandom);
    accept_req("abort", 2'd2, 4'd8, d);
    check_frame("abort", 2'd2, 4'd8, d, 9, -1, 1'b0, '0, '0, '0);
    check_idle("abort");

    abort = 1'b1;
    @(negedge clk);
    check_idle("abort_in_idle");
    d = DW'($urandom);
    accept_req("abort_accept", 2'd3, 4'd2, d);
    check_frame("abort_accept", 2'd3, 4'd2, d, -1, -1, 1'b0, '0, '0, '0);
    check_idle("abort_accept");

    d = DW'($urandom);
    accept_req("rst_mid", 2'd1, 4'd5, d);
    check_frame("rst_mid", 2'd1, 4'd5, d, -1, 5, 1'b0, '0, '0, '0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid ser",   32'(ser_out),   32'd1);
    chk("rst_mid busy",  32'(busy),      32'd0);
    chk("rst_mid done",  32'(done),      32'd0);
    chk("rst_mid ready", 32'(req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check_idle("rst_release");
    accept_req("after_rst", 2'd2, 4'd6, 15'h002D);
    check_frame("after_rst", 2'd2, 4'd6, 15'h002D, -1, -1, 1'b0, '0, '0, '0);
    check_idle("after_rst");

    for (int t = 0; t < 20; t++) begin
      p  = PW'($urandom);
      l  = LW'($urandom);
      d  = DW'($urandom);
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6 + int'(l))) : -1;
      accept_req($sformatf("rnd%0d", t), p, l, d);
      check_frame($sformatf("rnd%0d", t), p, l, d, ab, -1, 1'b0, '0, '0, '0);
      check_idle($sformatf("rnd%0d", t));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
